dmem_responder: RTL and testbench

- Data-memory responder: the target end of the CPU's MEM-stage load/store interface.
- Accepts one word request at a time over a valid/ready handshake and performs the read or byte-masked write on an internal word array.
- Returns a response (read data or write ack, plus error flag) after a fixed configurable latency; the response is held until the initiator takes it.
- Sits between the CPU MEM stage and the data memory array, replacing direct combinational dmem indexing.

---
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: the target of the CPU MEM-stage load/store interface.
// It serves one word request at a time and returns the response after a fixed latency.
module dmem_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic                resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_d;
    logic                resp_err_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   idx;
    logic                req_err;
    logic                accept;
    logic [DATA_W-1:0]   rd_word;

    assign idx     = req_addr[ADDR_W+1:2];
    assign req_err = (|req_addr[1:0]) | (|req_addr[31:ADDR_W+2]);
    assign req_ready = (state == S_IDLE) && !reset;
    assign accept  = req_valid && req_ready;
    // Loads sample the array at the acceptance edge; stores and errors carry zero data.
    assign rd_word = (!req_we && !req_err) ? mem[idx] : '0;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        data_d       = data_q;
        err_d        = err_q;
        resp_valid_d = resp_valid;
        resp_rdata_d = resp_rdata;
        resp_err_d   = resp_err;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    data_d = rd_word;
                    err_d  = req_err;
                    if (LATENCY == 1) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = rd_word;
                        resp_err_d   = req_err;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = data_q;
                    resp_err_d   = err_q;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            data_q     <= data_d;
            err_q      <= err_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
        end
    end

    // Store commits on its own acceptance edge so a following load sees it.
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_err) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (req_be[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance driven from a vector table
// plus hand sequences, and a LATENCY=1 instance for the back-to-back stream.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // LATENCY = 2 instance
    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_be;

    // LATENCY = 1 instance
    logic        s_req_valid, s_req_ready, s_req_we, s_resp_valid, s_resp_ready, s_resp_err;
    logic [31:0] s_req_addr, s_req_wdata, s_resp_rdata;
    logic [3:0]  s_req_be;

    dmem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(s_req_we),
        .req_addr(s_req_addr), .req_wdata(s_req_wdata), .req_be(s_req_be),
        .resp_valid(s_resp_valid), .resp_ready(s_resp_ready),
        .resp_rdata(s_resp_rdata), .resp_err(s_resp_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wdata,
                                logic [3:0] be, logic [31:0] exp_rdata, logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transaction on the LATENCY=2 instance; resp_ready held high.
    // Called one time unit after a rising edge with the DUT idle.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err,
                       output int lat);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          guard;
    int          acc_cyc, prev_acc;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        resp_ready = 1'b1;
        s_req_valid = 1'b0; s_req_we = 1'b0; s_req_addr = '0; s_req_wdata = '0; s_req_be = '0;
        s_resp_ready = 1'b1;

        vecs.push_back(mk(1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h20,  32'h0,        4'hF, 32'h11BB33DD, 1'b0));
        vecs.push_back(mk(1'b0, 32'h22,  32'h0,        4'hF, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h400, 32'h0,        4'hF, 32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 32'h21,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 32'h420, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0));
        vecs.push_back(mk(1'b1, 32'h24,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 32'h24,  32'h12345678, 4'h0, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h24,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0));
        vecs.push_back(mk(1'b1, 32'h3FC, 32'h0BADC0DE, 4'hF, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h3FC, 32'h0,        4'h0, 32'h0BADC0DE, 1'b0));

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // Table-driven transactions
        for (int i = 0; i < vecs.size(); i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        end

        // Back-pressure: response held for 5 cycles, stray req_valid ignored
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_addr = 32'h20; req_we = 1'b1; req_wdata = 32'h0; req_be = 4'hF;
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_resp_valid", k), 32'(resp_valid), 32'd1);
            check($sformatf("bp%0d_resp_rdata", k), resp_rdata, 32'hDEADBEEF);
            check($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp_taken_resp_valid", 32'(resp_valid), 32'd0);
        check("bp_taken_resp_rdata", resp_rdata, 32'h0);
        check("bp_taken_req_ready", 32'(req_ready), 32'd1);
        resp_ready = 1'b1;
        txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        check("bp_ignored_store", rd, 32'h11BB33DD);

        // Back-to-back stream on the LATENCY=1 instance
        prev_acc = 0;
        s_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_req_we    = (i < 4);
            s_req_addr  = 32'(i % 4) << 2;
            s_req_wdata = 32'hC0DE0000 + 32'(i);
            s_req_be    = 4'hF;
            guard = 0;
            while (!s_req_ready && guard < 10) begin
                @(posedge clk); #1;
                guard++;
            end
            acc_cyc = cyc;
            @(posedge clk); #1;
            check($sformatf("s%0d_resp_valid", i), 32'(s_resp_valid), 32'd1);
            check($sformatf("s%0d_resp_rdata", i), s_resp_rdata,
                  (i < 4) ? 32'h0 : 32'hC0DE0000 + 32'(i - 4));
            if (i > 0)
                check($sformatf("s%0d_accept_gap", i), 32'(acc_cyc - prev_acc), 32'd2);
            prev_acc = acc_cyc;
        end
        s_req_valid = 1'b0;
        @(posedge clk); #1;

        // Reset during WAIT after a store: store stays, response dropped
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h5A5A5A5A; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        check("rw_req_ready_in_reset", 32'(req_ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check($sformatf("rw%0d_resp_valid", k), 32'(resp_valid), 32'd0);
            check($sformatf("rw%0d_resp_rdata", k), resp_rdata, 32'h0);
            check($sformatf("rw%0d_resp_err", k), 32'(resp_err), 32'd0);
            check($sformatf("rw%0d_req_ready", k), 32'(req_ready), 32'd0);
        end
        // Reset coincident with a store request: reset wins
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("rw_post%0d_resp_valid", k), 32'(resp_valid), 32'd0);
        end
        txn(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
        check("rw_load_rdata", rd, 32'h5A5A5A5A);
        check("rw_load_err", 32'(er), 32'd0);
        check("rw_load_latency", 32'(lat), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
